// File: rtl/sdram_port_arb_pkg.sv
// Shared types and defaults for the two-port SDRAM command arbiter.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    localparam int DEF_AW         = 24;
    localparam int DEF_DW         = 16;
    localparam int DEF_RD_TIMEOUT = 64;

    // Word returned to the owner when the controller never answers a read.
    localparam logic [15:0] TIMEOUT_FILL = 16'hDEAD;

endpackage

// File: rtl/sdram_port_arb_if.sv
// Bundle of both requester ports plus the controller command/read-data side.
// The arbiter uses the slave view; the surrounding masters/controller use master.
interface sdram_port_arb_if
    import sdram_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic          p0_req;
    logic          p0_we;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic          p0_ack;
    logic [DW-1:0] p0_rdata;

    logic          p1_req;
    logic          p1_we;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic          p1_ack;
    logic [DW-1:0] p1_rdata;

    logic          cmd_valid;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          cmd_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          refresh_busy;
    logic          rd_timeout;
    logic          owner;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  cmd_ready, rd_valid, rd_data, refresh_busy,
        output p0_ack, p0_rdata, p1_ack, p1_rdata,
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata,
        output rd_timeout, owner
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output cmd_ready, rd_valid, rd_data, refresh_busy,
        input  p0_ack, p0_rdata, p1_ack, p1_rdata,
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata,
        input  rd_timeout, owner
    );

endinterface

// File: rtl/sdram_port_arb_rr.sv
// Two-way round-robin picker. pointer=0 favours port 0 on a tie.
// The next pointer always favours whichever port did not just win.
module sdram_arb_rr
    import sdram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       pointer,
    output logic [1:0] grant,
    output logic       next_pointer
);

    // Resolve a tie with the pointer, otherwise pass the lone requester through.
    always_comb begin
        grant        = req;
        next_pointer = pointer;
        if (req == 2'b11) begin
            grant = pointer ? 2'b10 : 2'b01;
        end
        if (grant[0]) begin
            next_pointer = 1'b1;
        end else if (grant[1]) begin
            next_pointer = 1'b0;
        end
    end

endmodule

// File: rtl/sdram_port_arb.sv
// Two-requester arbiter in front of the single-command SDRAM controller.
// One transaction in flight at a time; read data is routed back to the owner.
module sdram_port_arb
    import sdram_arb_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int RD_TIMEOUT = DEF_RD_TIMEOUT
)(
    input  logic              sys_clk,
    input  logic              sys_rst,
    sdram_port_arb_if.slave   bus
);

    localparam int            TW       = $clog2(RD_TIMEOUT) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(RD_TIMEOUT - 1);

    arb_state_t    state_reg;
    logic          rr_ptr_reg;
    logic          owner_reg;
    logic          cmd_valid_reg;
    logic          cmd_we_reg;
    logic [AW-1:0] cmd_addr_reg;
    logic [DW-1:0] cmd_wdata_reg;
    logic          p0_ack_reg;
    logic          p1_ack_reg;
    logic [DW-1:0] p0_rdata_reg;
    logic [DW-1:0] p1_rdata_reg;
    logic          rd_timeout_reg;
    logic [TW-1:0] tmo_cnt_reg;

    logic [1:0]    grant;
    logic          rr_ptr_next;
    logic [DW-1:0] rd_word;

    sdram_arb_rr u_rr (
        .req          ({bus.p1_req, bus.p0_req}),
        .pointer      (rr_ptr_reg),
        .grant        (grant),
        .next_pointer (rr_ptr_next)
    );

    // Word handed to the owner when a read finishes: real data or the timeout fill.
    assign rd_word = bus.rd_valid ? bus.rd_data : DW'(TIMEOUT_FILL);

    // Arbitration FSM; every output is a register so nothing glitches toward the controller.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg      <= IDLE;
            rr_ptr_reg     <= 1'b0;
            owner_reg      <= 1'b0;
            cmd_valid_reg  <= 1'b0;
            cmd_we_reg     <= 1'b0;
            cmd_addr_reg   <= '0;
            cmd_wdata_reg  <= '0;
            p0_ack_reg     <= 1'b0;
            p1_ack_reg     <= 1'b0;
            p0_rdata_reg   <= '0;
            p1_rdata_reg   <= '0;
            rd_timeout_reg <= 1'b0;
            tmo_cnt_reg    <= '0;
        end else begin
            // Completion strobes are single-cycle pulses.
            p0_ack_reg     <= 1'b0;
            p1_ack_reg     <= 1'b0;
            rd_timeout_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    // Refresh only gates new grants; in-flight work is never aborted.
                    if (!bus.refresh_busy && (bus.p0_req || bus.p1_req)) begin
                        owner_reg     <= grant[1];
                        rr_ptr_reg    <= rr_ptr_next;
                        cmd_we_reg    <= grant[1] ? bus.p1_we    : bus.p0_we;
                        cmd_addr_reg  <= grant[1] ? bus.p1_addr  : bus.p0_addr;
                        cmd_wdata_reg <= grant[1] ? bus.p1_wdata : bus.p0_wdata;
                        cmd_valid_reg <= 1'b1;
                        state_reg     <= ISSUE;
                    end
                end

                ISSUE: begin
                    // Latched command is held; requester-side changes are not looked at here.
                    if (bus.cmd_ready) begin
                        cmd_valid_reg <= 1'b0;
                        if (cmd_we_reg) begin
                            p0_ack_reg <= !owner_reg;
                            p1_ack_reg <= owner_reg;
                            state_reg  <= DONE;
                        end else begin
                            tmo_cnt_reg <= '0;
                            state_reg   <= WAIT_RD;
                        end
                    end
                end

                WAIT_RD: begin
                    // First strobe wins; a silent controller is cut off after RD_TIMEOUT cycles.
                    if (bus.rd_valid || (tmo_cnt_reg == TMO_LAST)) begin
                        if (owner_reg) begin
                            p1_rdata_reg <= rd_word;
                        end else begin
                            p0_rdata_reg <= rd_word;
                        end
                        rd_timeout_reg <= !bus.rd_valid;
                        p0_ack_reg     <= !owner_reg;
                        p1_ack_reg     <= owner_reg;
                        state_reg      <= DONE;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
                    end
                end

                DONE: begin
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_valid  = cmd_valid_reg;
    assign bus.cmd_we     = cmd_we_reg;
    assign bus.cmd_addr   = cmd_addr_reg;
    assign bus.cmd_wdata  = cmd_wdata_reg;
    assign bus.p0_ack     = p0_ack_reg;
    assign bus.p1_ack     = p1_ack_reg;
    assign bus.p0_rdata   = p0_rdata_reg;
    assign bus.p1_rdata   = p1_rdata_reg;
    assign bus.rd_timeout = rd_timeout_reg;
    assign bus.owner      = owner_reg;

endmodule

// File: tb/tb_sdram_port_arb.sv
// Self-checking bench for sdram_port_arb: directed scenarios followed by a
// randomized phase, all predicted by a transaction-level model of the arbiter.
module tb_sdram_port_arb;
    import sdram_arb_pkg::*;

    localparam int AW  = 24;
    localparam int DW  = 16;
    localparam int RDT = 64;

    logic sys_clk = 1'b0;
    logic sys_rst;

    always #5 sys_clk = ~sys_clk;

    sdram_port_arb_if #(.AW(AW), .DW(DW)) bus ();

    sdram_port_arb #(.AW(AW), .DW(DW), .RD_TIMEOUT(RDT)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Transaction-level model: what each port wants, what it last read, who won last.
    bit            pend    [2];
    bit            m_we    [2];
    logic [AW-1:0] m_addr  [2];
    logic [DW-1:0] m_wdata [2];
    logic [DW-1:0] m_rdata [2];
    int            last_grant;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge sys_clk);
    endtask

    function automatic logic get_ack(input int p);
        return (p == 0) ? bus.p0_ack : bus.p1_ack;
    endfunction

    function automatic logic [DW-1:0] get_rdata(input int p);
        return (p == 0) ? bus.p0_rdata : bus.p1_rdata;
    endfunction

    // Tie goes to whoever did not win last; a lone requester always wins.
    function automatic int predict();
        if (pend[0] && pend[1]) return (last_grant == 0) ? 1 : 0;
        return pend[0] ? 0 : 1;
    endfunction

    task automatic drive_port(input int p);
        if (p == 0) begin
            bus.p0_req = pend[0]; bus.p0_we = m_we[0];
            bus.p0_addr = m_addr[0]; bus.p0_wdata = m_wdata[0];
        end else begin
            bus.p1_req = pend[1]; bus.p1_we = m_we[1];
            bus.p1_addr = m_addr[1]; bus.p1_wdata = m_wdata[1];
        end
    endtask

    task automatic new_req(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pend[p] = 1'b1; m_we[p] = we; m_addr[p] = a; m_wdata[p] = d;
        drive_port(p);
    endtask

    task automatic new_rand_req(input int p);
        new_req(p, 1'($urandom), AW'($urandom), DW'($urandom));
    endtask

    task automatic poke_port(input int p, input bit req, input logic [AW-1:0] a);
        if (p == 0) begin bus.p0_req = req; bus.p0_addr = a; end
        else        begin bus.p1_req = req; bus.p1_addr = a; end
    endtask

    // One complete transaction. exp_lat<0 skips the latency check; rd_delay<0 means
    // the controller never returns data. Returns at the negedge where ack is visible.
    task automatic do_txn(input int exp_lat, input int rdy_delay, input int rd_delay,
                          input logic [DW-1:0] rdv, input bit drop_req, output int w);
        int n;
        int o;
        w = predict();
        o = 1 - w;
        n = 0;
        while (!bus.cmd_valid && n < 200) begin
            step();
            n++;
            chk("ack_one_shot", {30'd0, bus.p1_ack, bus.p0_ack}, 32'd0);
        end
        if (n >= 200) begin
            chk("cmd_valid_timeout", 32'(n), 32'd0);
            return;
        end
        if (exp_lat >= 0) chk("grant_latency", 32'(n), 32'(exp_lat));
        chk("owner", 32'(bus.owner), 32'(w));
        chk("cmd_we", 32'(bus.cmd_we), 32'(m_we[w]));
        chk("cmd_addr", 32'(bus.cmd_addr), 32'(m_addr[w]));
        chk("cmd_wdata", 32'(bus.cmd_wdata), 32'(m_wdata[w]));
        last_grant = w;

        if (drop_req) poke_port(w, 1'b0, m_addr[w]);
        for (int i = 0; i < rdy_delay; i++) begin
            poke_port(w, drop_req ? 1'b0 : 1'b1, AW'($urandom));
            bus.rd_valid = 1'($urandom);
            bus.rd_data  = DW'($urandom);
            step();
            chk("cmd_hold_valid", 32'(bus.cmd_valid), 32'd1);
            chk("cmd_hold_addr", 32'(bus.cmd_addr), 32'(m_addr[w]));
        end
        bus.rd_valid  = 1'b0;
        bus.cmd_ready = 1'b1;
        step();
        bus.cmd_ready = 1'b0;
        chk("cmd_valid_drop", 32'(bus.cmd_valid), 32'd0);

        if (!m_we[w]) begin
            if (rd_delay < 0) begin
                for (int i = 1; i < RDT; i++) begin
                    step();
                    chk("tmo_early", {30'd0, bus.rd_timeout, get_ack(w)}, 32'd0);
                end
                step();
                m_rdata[w] = TIMEOUT_FILL;
                chk("rd_timeout_pulse", 32'(bus.rd_timeout), 32'd1);
            end else begin
                for (int i = 0; i < rd_delay; i++) begin
                    step();
                    chk("rd_wait_no_ack", 32'(get_ack(w)), 32'd0);
                end
                bus.rd_valid = 1'b1;
                bus.rd_data  = rdv;
                step();
                bus.rd_valid = 1'b0;
                m_rdata[w] = rdv;
                chk("rd_no_timeout", 32'(bus.rd_timeout), 32'd0);
            end
        end
        chk("owner_ack", 32'(get_ack(w)), 32'd1);
        chk("other_ack", 32'(get_ack(o)), 32'd0);
        chk("owner_rdata", 32'(get_rdata(w)), 32'(m_rdata[w]));
        chk("other_rdata", 32'(get_rdata(o)), 32'(m_rdata[o]));
        pend[w] = 1'b0;
        drive_port(w);
    endtask

    initial begin
        int w;
        int lat;

        sys_rst = 1'b1;
        bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = '0; bus.p0_wdata = '0;
        bus.p1_req = 0; bus.p1_we = 0; bus.p1_addr = '0; bus.p1_wdata = '0;
        bus.cmd_ready = 0; bus.rd_valid = 0; bus.rd_data = '0; bus.refresh_busy = 0;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 0; m_we[p] = 0; m_addr[p] = '0; m_wdata[p] = '0; m_rdata[p] = '0;
        end
        last_grant = 1;
        repeat (3) step();
        chk("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
        chk("rst_acks", {30'd0, bus.p1_ack, bus.p0_ack}, 32'd0);
        chk("rst_owner", 32'(bus.owner), 32'd0);
        chk("rst_cmd_addr", 32'(bus.cmd_addr), 32'd0);
        sys_rst = 1'b0;
        step();

        // Single write on port 0, accepted two cycles after cmd_valid.
        new_req(0, 1'b1, 24'h000010, 16'h1234);
        do_txn(1, 2, 0, '0, 1'b0, w);
        $display("txn write p0 owner=%0d", w);
        step();

        // Read on port 1 returning 16'hBEEF.
        new_req(1, 1'b0, 24'h0000A0, 16'h0000);
        do_txn(1, 0, 5, 16'hBEEF, 1'b0, w);
        $display("txn read p1 owner=%0d rdata=%h", w, bus.p1_rdata);

        // Both ports requesting continuously: grants alternate 0,1,0,1.
        new_rand_req(0);
        new_rand_req(1);
        for (int i = 0; i < 4; i++) begin
            do_txn(i == 0 ? 2 : 2, int'($urandom_range(0, 2)), int'($urandom_range(0, 4)),
                   DW'($urandom), 1'b0, w);
            chk("alternate_grant", 32'(w), 32'(i % 2));
            $display("txn alternate %0d owner=%0d", i, w);
            if (i < 3) new_rand_req(w);
        end
        do_txn(2, 0, 1, DW'($urandom), 1'b0, w);
        $display("txn drain owner=%0d", w);
        step();

        // Refresh holds off the grant for its whole duration.
        bus.refresh_busy = 1'b1;
        new_req(0, 1'b1, 24'h123456, 16'h5A5A);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("refresh_block", 32'(bus.cmd_valid), 32'd0);
        end
        bus.refresh_busy = 1'b0;
        do_txn(1, 0, 0, '0, 1'b0, w);
        $display("txn after refresh owner=%0d", w);
        step();

        // Read that the controller never answers, then a normal read.
        new_req(1, 1'b0, 24'h000777, 16'h0);
        do_txn(1, 1, -1, '0, 1'b0, w);
        $display("txn timeout owner=%0d rdata=%h", w, bus.p1_rdata);
        new_req(1, 1'b0, 24'h000778, 16'h0);
        do_txn(2, 0, 3, 16'h4321, 1'b0, w);
        $display("txn read after timeout owner=%0d rdata=%h", w, bus.p1_rdata);

        // Randomized phase: back-to-back, dropped requests, stalls, timeouts.
        lat = 1;
        step();
        new_rand_req($urandom_range(0, 1));
        for (int t = 0; t < 40; t++) begin
            do_txn(lat, int'($urandom_range(0, 3)),
                   ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 8)),
                   DW'($urandom), 1'($urandom_range(0, 3) == 0), w);
            $display("txn rand %0d owner=%0d we=%0d", t, w, m_we[w]);
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 1) == 1) new_rand_req(p);
            end
            if (pend[0] || pend[1]) begin
                lat = 2;
            end else begin
                repeat ($urandom_range(1, 3)) step();
                case ($urandom_range(1, 3))
                    1: new_rand_req(0);
                    2: new_rand_req(1);
                    default: begin new_rand_req(0); new_rand_req(1); end
                endcase
                lat = 1;
            end
        end
        while (pend[0] || pend[1]) begin
            do_txn(-1, 0, 0, DW'($urandom), 1'b0, w);
            $display("txn flush owner=%0d", w);
        end
        step();

        // Asynchronous reset while a port-1 read is waiting for data.
        new_req(1, 1'b0, 24'h00ABCD, 16'h0);
        begin
            int n;
            n = 0;
            while (!bus.cmd_valid && n < 50) begin step(); n++; end
            chk("rst_test_cmd_valid", 32'(bus.cmd_valid), 32'd1);
            bus.cmd_ready = 1'b1;
            step();
            bus.cmd_ready = 1'b0;
            repeat (3) step();
        end
        sys_rst = 1'b1;
        #1;
        chk("async_rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
        chk("async_rst_owner", 32'(bus.owner), 32'd0);
        chk("async_rst_rdata", {bus.p1_rdata, bus.p0_rdata}, 32'd0);
        chk("async_rst_misc", {29'd0, bus.rd_timeout, bus.p1_ack, bus.p0_ack}, 32'd0);
        $display("txn async reset applied");
        pend[1] = 1'b0;
        drive_port(1);
        step();
        sys_rst = 1'b0;
        last_grant = 1;
        m_rdata[0] = '0;
        m_rdata[1] = '0;
        new_rand_req(0);
        new_rand_req(1);
        do_txn(1, 0, 2, DW'($urandom), 1'b0, w);
        chk("post_rst_first_grant", 32'(w), 32'd0);
        $display("txn post reset owner=%0d", w);
        do_txn(2, 0, 2, DW'($urandom), 1'b0, w);
        $display("txn post reset owner=%0d", w);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop so the run always terminates even if the DUT wedges.
    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

endmodule
